// File: rtl/midi_message_parser_pkg.sv
// Shared MIDI definitions: message/state enums, status-class codes,
// system byte values and the UART baud rate used upstream.
package midi_message_parser_pkg;

    localparam int BAUD_RATE = 31250;

    typedef enum logic [1:0] {
        MSG_NOTE_OFF       = 2'd0,
        MSG_NOTE_ON        = 2'd1,
        MSG_CONTROL_CHANGE = 2'd2,
        MSG_PITCH_BEND     = 2'd3
    } midi_msg_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } parse_state_t;

    // Upper nibble of a channel status byte
    localparam logic [3:0] CLS_NOTE_OFF = 4'h8;
    localparam logic [3:0] CLS_NOTE_ON  = 4'h9;
    localparam logic [3:0] CLS_POLY_AT  = 4'hA;
    localparam logic [3:0] CLS_CC       = 4'hB;
    localparam logic [3:0] CLS_PROG     = 4'hC;
    localparam logic [3:0] CLS_CHAN_AT  = 4'hD;
    localparam logic [3:0] CLS_PITCH    = 4'hE;

    localparam logic [7:0] SYSEX_START  = 8'hF0;
    localparam logic [7:0] SYSEX_END    = 8'hF7;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;

endpackage

// File: rtl/midi_byte_classifier.sv
// Combinational classification of one received MIDI byte.
// Ports: byte_in -> is_status, is_realtime, is_channel, is_sysex_start,
//        is_sysex_end, len_one (Cx/Dx carry a single data byte).
module midi_byte_classifier
    import midi_message_parser_pkg::*;
(
    input  logic [7:0] byte_in,
    output logic       is_status,
    output logic       is_realtime,
    output logic       is_channel,
    output logic       is_sysex_start,
    output logic       is_sysex_end,
    output logic       len_one
);

    assign is_status      = byte_in[7];
    assign is_realtime    = byte_in >= REALTIME_MIN;
    assign is_channel     = byte_in[7] && (byte_in[7:4] != 4'hF);
    assign is_sysex_start = byte_in == SYSEX_START;
    assign is_sysex_end   = byte_in == SYSEX_END;
    assign len_one        = (byte_in[7:4] == CLS_PROG) ||
                            (byte_in[7:4] == CLS_CHAN_AT);

endmodule

// File: rtl/midi_message_parser.sv
// Byte-level MIDI channel-voice parser with running status.
// Ports: clock_50_000_000, reset (sync, active-high), data_in/data_in_ready
//        in; message_valid/type/channel/data1/data2, framing_error,
//        midi_info (6 debug nibbles), midi_info_en out. All outputs registered.
module midi_message_parser
    import midi_message_parser_pkg::*;
#(
    parameter int         BYTE_WIDTH        = 8,
    parameter bit         CHANNEL_FILTER_EN = 1'b0,
    parameter logic [3:0] CHANNEL           = 4'd0
) (
    input  logic                  clock_50_000_000,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] data_in,
    input  logic                  data_in_ready,
    output logic                  message_valid,
    output logic [1:0]            message_type,
    output logic [3:0]            message_channel,
    output logic [6:0]            message_data1,
    output logic [6:0]            message_data2,
    output logic                  framing_error,
    output logic [5:0][3:0]       midi_info,
    output logic [5:0]            midi_info_en
);

    parse_state_t state;
    logic [7:0]   running_status;
    logic         len_one_q;
    logic [6:0]   data1_q;

    logic [7:0]   b;
    logic         is_status;
    logic         is_realtime;
    logic         is_channel;
    logic         is_sysex_start;
    logic         is_sysex_end;
    logic         len_one;

    assign b = data_in[7:0];

    midi_byte_classifier u_classifier (
        .byte_in        (b),
        .is_status      (is_status),
        .is_realtime    (is_realtime),
        .is_channel     (is_channel),
        .is_sysex_start (is_sysex_start),
        .is_sysex_end   (is_sysex_end),
        .len_one        (len_one)
    );

    midi_msg_t  emit_type;
    logic       emit_supported;
    logic       channel_ok;
    logic [6:0] emit_d2;

    always_comb begin
        emit_type      = MSG_NOTE_OFF;
        emit_supported = 1'b0;
        emit_d2        = b[6:0];
        unique case (1'b1)
            running_status[7:4] == CLS_NOTE_OFF: begin
                emit_supported = 1'b1;
            end
            running_status[7:4] == CLS_NOTE_ON: begin
                emit_supported = 1'b1;
                // Velocity 0 is a note-off in disguise
                emit_type = (b[6:0] == 7'd0) ? MSG_NOTE_OFF : MSG_NOTE_ON;
            end
            running_status[7:4] == CLS_CC: begin
                emit_supported = 1'b1;
                emit_type      = MSG_CONTROL_CHANGE;
            end
            running_status[7:4] == CLS_PITCH: begin
                emit_supported = 1'b1;
                emit_type      = MSG_PITCH_BEND;
            end
            default: begin
                emit_supported = 1'b0;
            end
        endcase
    end

    assign channel_ok = !CHANNEL_FILTER_EN ||
                        (running_status[3:0] == CHANNEL);

    always_ff @(posedge clock_50_000_000) begin
        message_valid <= 1'b0;
        framing_error <= 1'b0;
        if (reset) begin
            state           <= ST_IDLE;
            running_status  <= 8'd0;
            len_one_q       <= 1'b0;
            data1_q         <= 7'd0;
            message_type    <= 2'd0;
            message_channel <= 4'd0;
            message_data1   <= 7'd0;
            message_data2   <= 7'd0;
            midi_info       <= '0;
            midi_info_en    <= 6'd0;
        end else if (data_in_ready && !is_realtime) begin
            if (is_status) begin
                // Only WAIT_D2 can hold a partially received message
                if (state == ST_WAIT_D2) begin
                    framing_error <= 1'b1;
                end
                if (is_channel) begin
                    running_status <= b;
                    len_one_q      <= len_one;
                    state          <= ST_WAIT_D1;
                end else if (is_sysex_start) begin
                    running_status <= 8'd0;
                    state          <= ST_SYSEX;
                end else if (is_sysex_end) begin
                    running_status <= 8'd0;
                    state          <= ST_IDLE;
                end else begin
                    running_status <= 8'd0;
                    state          <= ST_IDLE;
                end
            end else begin
                unique case (state)
                    ST_WAIT_D1: begin
                        data1_q <= b[6:0];
                        // One-byte messages complete here but are not emitted
                        if (!len_one_q) begin
                            state <= ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        state <= ST_WAIT_D1;
                        if (emit_supported && channel_ok) begin
                            message_valid   <= 1'b1;
                            message_type    <= emit_type;
                            message_channel <= running_status[3:0];
                            message_data1   <= data1_q;
                            message_data2   <= emit_d2;
                            midi_info       <= {running_status,
                                                1'b0, data1_q,
                                                1'b0, emit_d2};
                            midi_info_en    <= 6'b111111;
                        end
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed table-driven bench for midi_message_parser, plus hand
// sequences for channel filtering and reset during a message.
module tb_midi_message_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        rdy;

    logic        mv, fe, fmv, ffe;
    logic [1:0]  mt, fmt;
    logic [3:0]  mc, fmc;
    logic [6:0]  md1, md2, fmd1, fmd2;
    logic [5:0][3:0] info, finfo;
    logic [5:0]  info_en, finfo_en;

    always #10 clk = ~clk;

    midi_message_parser dut (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .data_in          (data_in),
        .data_in_ready    (rdy),
        .message_valid    (mv),
        .message_type     (mt),
        .message_channel  (mc),
        .message_data1    (md1),
        .message_data2    (md2),
        .framing_error    (fe),
        .midi_info        (info),
        .midi_info_en     (info_en)
    );

    midi_message_parser #(
        .BYTE_WIDTH        (8),
        .CHANNEL_FILTER_EN (1'b1),
        .CHANNEL           (4'd0)
    ) dut_f (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .data_in          (data_in),
        .data_in_ready    (rdy),
        .message_valid    (fmv),
        .message_type     (fmt),
        .message_channel  (fmc),
        .message_data1    (fmd1),
        .message_data2    (fmd2),
        .framing_error    (ffe),
        .midi_info        (finfo),
        .midi_info_en     (finfo_en)
    );

    localparam logic [1:0] T_OFF = 2'd0;
    localparam logic [1:0] T_ON  = 2'd1;
    localparam logic [1:0] T_CC  = 2'd2;
    localparam logic [1:0] T_PB  = 2'd3;

    typedef struct {
        logic [7:0] b;
        logic       v;
        logic [1:0] t;
        logic [7:0] st;
        logic [6:0] d1;
        logic [6:0] d2;
        logic       fe;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int passed = 0;

    logic [1:0] h_t;
    logic [7:0] h_st;
    logic [6:0] h_d1, h_d2;
    logic [5:0] h_en;

    function automatic vec_t nv(logic [7:0] b);
        vec_t r = '{b, 1'b0, 2'd0, 8'd0, 7'd0, 7'd0, 1'b0};
        return r;
    endfunction

    function automatic vec_t fv(logic [7:0] b);
        vec_t r = '{b, 1'b0, 2'd0, 8'd0, 7'd0, 7'd0, 1'b1};
        return r;
    endfunction

    function automatic vec_t ev(logic [7:0] b, logic [1:0] t,
                                logic [7:0] st, logic [6:0] d1,
                                logic [6:0] d2);
        vec_t r = '{b, 1'b1, t, st, d1, d2, 1'b0};
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_model();
        h_t = 0; h_st = 0; h_d1 = 0; h_d2 = 0; h_en = 0;
    endtask

    task automatic check_all(string tag, logic ev_, logic efe);
        check({tag, ".valid"}, 32'(mv), 32'(ev_));
        check({tag, ".ferr"}, 32'(fe), 32'(efe));
        check({tag, ".type"}, 32'(mt), 32'(h_t));
        check({tag, ".chan"}, 32'(mc), 32'(h_st[3:0]));
        check({tag, ".d1"}, 32'(md1), 32'(h_d1));
        check({tag, ".d2"}, 32'(md2), 32'(h_d2));
        check({tag, ".info"}, 32'(info),
              32'({h_st, 1'b0, h_d1, 1'b0, h_d2}));
        check({tag, ".info_en"}, 32'(info_en), 32'(h_en));
    endtask

    task automatic apply_check(int k);
        if (vecs[k].v) begin
            h_t = vecs[k].t; h_st = vecs[k].st;
            h_d1 = vecs[k].d1; h_d2 = vecs[k].d2;
            h_en = 6'h3F;
        end
        check_all($sformatf("vec%0d", k), vecs[k].v, vecs[k].fe);
    endtask

    task automatic send_byte(logic [7:0] b);
        @(negedge clk);
        data_in = b;
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        data_in = 8'd0;
        rdy = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_all("reset", 1'b0, 1'b0);

        // Basic note on
        vecs.push_back(nv(8'h90));
        vecs.push_back(nv(8'h3C));
        vecs.push_back(ev(8'h64, T_ON, 8'h90, 7'h3C, 7'h64));
        // Running status, velocity 0 note on
        vecs.push_back(nv(8'h93));
        vecs.push_back(nv(8'h3C));
        vecs.push_back(ev(8'h64, T_ON, 8'h93, 7'h3C, 7'h64));
        vecs.push_back(nv(8'h40));
        vecs.push_back(ev(8'h00, T_OFF, 8'h93, 7'h40, 7'h00));
        // Realtime bytes interleaved
        vecs.push_back(nv(8'h90));
        vecs.push_back(nv(8'hF8));
        vecs.push_back(nv(8'h3C));
        vecs.push_back(nv(8'hFE));
        vecs.push_back(ev(8'h64, T_ON, 8'h90, 7'h3C, 7'h64));
        // Truncation by a new status
        vecs.push_back(nv(8'h90));
        vecs.push_back(nv(8'h3C));
        vecs.push_back(fv(8'hB1));
        vecs.push_back(nv(8'h07));
        vecs.push_back(ev(8'h7F, T_CC, 8'hB1, 7'h07, 7'h7F));
        // SysEx, then stray data in IDLE
        vecs.push_back(nv(8'hF0));
        vecs.push_back(nv(8'h01));
        vecs.push_back(nv(8'hF8));
        vecs.push_back(nv(8'h02));
        vecs.push_back(nv(8'hF7));
        vecs.push_back(nv(8'h3C));
        vecs.push_back(nv(8'h64));
        // Program change: one-byte, never emitted
        vecs.push_back(nv(8'hC0));
        vecs.push_back(nv(8'h05));
        vecs.push_back(nv(8'h3C));
        // Pitch bend
        vecs.push_back(nv(8'hE2));
        vecs.push_back(nv(8'h00));
        vecs.push_back(ev(8'h40, T_PB, 8'hE2, 7'h00, 7'h40));
        // Poly aftertouch parsed but not emitted
        vecs.push_back(nv(8'hA5));
        vecs.push_back(nv(8'h3C));
        vecs.push_back(nv(8'h40));
        // Plain note off
        vecs.push_back(nv(8'h80));
        vecs.push_back(nv(8'h3C));
        vecs.push_back(ev(8'h40, T_OFF, 8'h80, 7'h3C, 7'h40));
        // System common truncates; its data is dropped in IDLE
        vecs.push_back(nv(8'hE2));
        vecs.push_back(nv(8'h00));
        vecs.push_back(fv(8'hF3));
        vecs.push_back(nv(8'h10));
        vecs.push_back(nv(8'h20));
        // Channel 15, velocity 0 note on
        vecs.push_back(nv(8'h9F));
        vecs.push_back(nv(8'h7F));
        vecs.push_back(ev(8'h00, T_OFF, 8'h9F, 7'h7F, 7'h00));
        // F7 inside a partial message
        vecs.push_back(nv(8'h01));
        vecs.push_back(fv(8'hF7));
        vecs.push_back(nv(8'h01));

        // Back-to-back strobes: check each result while driving the next
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (i > 0) apply_check(i - 1);
            data_in = vecs[i].b;
            rdy = 1'b1;
        end
        @(negedge clk);
        rdy = 1'b0;
        apply_check(vecs.size() - 1);

        // Reset clears outputs of both instances
        do_reset();
        clear_model();
        check_all("reset2", 1'b0, 1'b0);
        check("f_reset.info_en", 32'(finfo_en), 32'd0);
        check("f_reset.d1", 32'(fmd1), 32'd0);

        // Filtered instance drops other channels
        send_byte(8'h91);
        send_byte(8'h3C);
        send_byte(8'h64);
        check("f_ch1.valid", 32'(fmv), 32'd0);
        check("f_ch1.info_en", 32'(finfo_en), 32'd0);
        check("f_ch1.info", 32'(finfo), 32'd0);
        check("nf_ch1.valid", 32'(mv), 32'd1);
        check("nf_ch1.chan", 32'(mc), 32'd1);

        send_byte(8'h90);
        send_byte(8'h3C);
        send_byte(8'h64);
        check("f_ch0.valid", 32'(fmv), 32'd1);
        check("f_ch0.type", 32'(fmt), 32'(T_ON));
        check("f_ch0.chan", 32'(fmc), 32'd0);
        check("f_ch0.d1", 32'(fmd1), 32'h3C);
        check("f_ch0.d2", 32'(fmd2), 32'h64);
        check("f_ch0.info", 32'(finfo), 32'h903C64);
        check("f_ch0.info_en", 32'(finfo_en), 32'h3F);
        @(negedge clk);
        check("f_ch0.pulse_end", 32'(fmv), 32'd0);

        // Reset mid-message discards the partial note
        send_byte(8'h90);
        send_byte(8'h3C);
        do_reset();
        send_byte(8'h64);
        check("rst_mid.f_valid", 32'(fmv), 32'd0);
        check("rst_mid.valid", 32'(mv), 32'd0);
        check("rst_mid.info_en", 32'(info_en), 32'd0);
        check("rst_mid.f_d2", 32'(fmd2), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
